// File: rtl/io_reg_responder.sv
// io_reg_responder
//   Wishbone-classic responder on the device side of the I/O bridge. Decodes a window in
//   the 1MB I/O space and serves a small register bank with programmable wait states.
//   Register 0 drives ctrl_o. The two top indices are read-only: status_i, then a free-running
//   cycle counter. Ack is held until the strobe drops.
// Ports
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   cyc_i     bus cycle active
//   stb_i     strobe
//   ack_o     acknowledge (registered)
//   we_i      1 = write, 0 = read
//   sel_i     byte-lane selects for writes
//   adr_i     byte address, bits [31:20] not decoded
//   dat_i     write data
//   dat_o     read data (registered), zero whenever ack_o is low so the bus can OR responders
//   status_i  status word, sampled when a read enters ACK
//   ctrl_o    contents of register 0
module io_reg_responder #(
    parameter logic [19:0] BASE    = 20'hD0000,
    parameter int unsigned AW      = 3,
    parameter int unsigned WAIT_ST = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic        ack_o,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [31:0] status_i,
    output logic [31:0] ctrl_o
);

    localparam int unsigned NREGS   = 2 ** AW;
    localparam int unsigned NRW     = NREGS - 2;
    localparam int unsigned WaitM1  = (WAIT_ST > 0) ? WAIT_ST - 1 : 0;
    localparam logic [3:0]  WaitInit = 4'(WaitM1);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e        state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   cnt_q;
    logic [31:0]   regs_q [NREGS];
    logic [31:0]   rdata;
    logic          hit;
    logic          enter_ack;
    logic          wr_commit;
    logic [AW-1:0] idx;

    logic unused_adr;
    assign unused_adr = ^{adr_i[31:20], adr_i[1:0]};

    assign idx = adr_i[AW+1:2];
    assign hit = cyc_i & stb_i & (adr_i[19:AW+2] == BASE[19:AW+2]);

    // State register plus the registered bus outputs and the register bank.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_q + 32'd1;
            if (wr_commit) begin
                for (int k = 0; k < 4; k++) begin
                    if (sel_i[k]) regs_q[idx][8*k +: 8] <= dat_i[8*k +: 8];
                end
            end
        end
    end

    // Next-state logic. WAIT only watches cyc/stb; the address is assumed stable per access.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    if (WAIT_ST == 0) begin
                        state_d = StAck;
                    end else begin
                        state_d = StWait;
                        wcnt_d  = WaitInit;
                    end
                end
            end
            StWait: begin
                if (!(cyc_i && stb_i)) state_d = StIdle;
                else if (wcnt_q == 4'd0) state_d = StAck;
                else wcnt_d = wcnt_q - 4'd1;
            end
            StAck: begin
                if (!(cyc_i && stb_i)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Read mux: R/W bank, then status, then the counter value before this edge.
    always_comb begin
        rdata = cnt_q;
        if (32'(idx) < NRW) rdata = regs_q[idx];
        else if (32'(idx) == NREGS - 2) rdata = status_i;
    end

    // Output logic: the write and read load happen only on the edge entering ACK, so a strobe
    // held high in ACK never re-executes the access.
    always_comb begin
        enter_ack = (state_q != StAck) && (state_d == StAck);
        wr_commit = enter_ack && we_i && (32'(idx) < NRW);
        ack_d     = (state_d == StAck);
        dat_d     = '0;
        if (enter_ack && !we_i) dat_d = rdata;
        else if (state_q == StAck && state_d == StAck) dat_d = dat_q;
    end

    assign ack_o  = ack_q;
    assign dat_o  = dat_q;
    assign ctrl_o = regs_q[0];

endmodule
